instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_queue.sv | 48 ++++
 rtl/instr_fetch.sv | 69 ++++++
 tb/tb_instr_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam int FETCH_DEPTH = 2;
  localparam int PC_STEP     = 4;
  localparam int FETCH_WIDTH = 32;

  typedef struct packed {
    logic [31:0]            pc;
    logic [FETCH_WIDTH-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Two-entry ring-buffer FIFO of fetched {pc, instr} pairs with flush.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);
  fetch_entry_t mem [FETCH_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the top gates the head with empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'(FETCH_DEPTH));
  assign empty = (count == 2'd0);
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, combinational-ROM addressing and a 2-deep decode queue.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter int          SIZE     = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [SIZE-1:0]  rom_addr,
  input  logic [WIDTH-1:0] rom_dout,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [WIDTH-1:0] out_instr
);
  logic [31:0]  fetch_pc;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic         unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pop  = out_valid && out_ready;
  assign push = !halt && !redirect_valid && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'(PC_STEP);
    end
  end

  // Upper PC bits are simply dropped, so out-of-range PCs alias low ROM words.
  assign rom_addr = fetch_pc[SIZE+1:2];

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = fetch_pc;
    push_entry.instr = FETCH_WIDTH'(rom_dout);
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  assign out_valid = !empty;
  assign out_pc    = empty ? 32'd0 : head.pc;
  assign out_instr = empty ? '0 : WIDTH'(head.instr);
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a ROM whose word i holds 0x1000+i.
module tb_instr_fetch;
  logic        clk;
  logic        rst_n;
  logic [9:0]  rom_addr;
  logic [31:0] rom_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int checks;
  int failures;

  instr_fetch #(.WIDTH(32), .SIZE(10), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_dout       (rom_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  assign rom_dout = 32'h1000 + {22'd0, rom_addr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; halt = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    #3;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++;
    if (out_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    checks++;
    if (out_instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
    checks++;
    if (rom_addr !== 10'd0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_held_valid got=%0b exp=0", out_valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== 32'(32'h1000 + k)) begin
        failures++;
        $display("FAIL stream[%0d] got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                 k, out_valid, out_pc, out_instr, 4 * k, 32'h1000 + k);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== 32'h1000) begin
        failures++;
        $display("FAIL bp_head[%0d] got v=%0b pc=%h instr=%h exp v=1 pc=0 instr=1000",
                 k, out_valid, out_pc, out_instr);
      end
    end
    checks++;
    if (rom_addr !== 10'd2) begin failures++; $display("FAIL bp_fetch_pc got rom_addr=%h exp=2", rom_addr); end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++;
      if (out_pc !== 32'(4 * k) || out_instr !== 32'(32'h1000 + k)) begin
        failures++;
        $display("FAIL bp_resume[%0d] got pc=%h instr=%h exp pc=%h instr=%h",
                 k, out_pc, out_instr, 4 * k, 32'h1000 + k);
      end
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 10'h10) begin
      failures++;
      $display("FAIL redirect_flush got v=%0b rom_addr=%h exp v=0 rom_addr=10", out_valid, rom_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h1010) begin
      failures++;
      $display("FAIL redirect_target got v=%0b pc=%h instr=%h exp v=1 pc=40 instr=1010",
               out_valid, out_pc, out_instr);
    end
    tick();
    checks++;
    if (out_pc !== 32'h44 || out_instr !== 32'h1011) begin
      failures++;
      $display("FAIL redirect_next got pc=%h instr=%h exp pc=44 instr=1011", out_pc, out_instr);
    end
  endtask

  task automatic test_halt();
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (out_pc !== 32'h44 || out_instr !== 32'h1011 || rom_addr !== 10'h13) begin
      failures++;
      $display("FAIL stall_stable got pc=%h instr=%h rom_addr=%h exp pc=44 instr=1011 rom_addr=13",
               out_pc, out_instr, rom_addr);
    end
    halt = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h48) begin
      failures++;
      $display("FAIL halt_pop1 got v=%0b pc=%h exp v=1 pc=48", out_valid, out_pc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'd0) begin
      failures++;
      $display("FAIL halt_drained got v=%0b pc=%h exp v=0 pc=0", out_valid, out_pc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 10'h13) begin
      failures++;
      $display("FAIL halt_hold got v=%0b rom_addr=%h exp v=0 rom_addr=13", out_valid, rom_addr);
    end
    halt = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4C || out_instr !== 32'h1013) begin
      failures++;
      $display("FAIL halt_resume got v=%0b pc=%h instr=%h exp v=1 pc=4c instr=1013",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFA;
    halt = 1'b1;
    tick();
    redirect_valid = 1'b0;
    halt = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 10'h3FE) begin
      failures++;
      $display("FAIL wrap_redirect got v=%0b rom_addr=%h exp v=0 rom_addr=3fe", out_valid, rom_addr);
    end
    tick();
    checks++;
    if (out_pc !== 32'hFF8 || out_instr !== 32'h13FE) begin
      failures++;
      $display("FAIL wrap_ff8 got pc=%h instr=%h exp pc=ff8 instr=13fe", out_pc, out_instr);
    end
    tick();
    checks++;
    if (out_pc !== 32'hFFC || out_instr !== 32'h13FF) begin
      failures++;
      $display("FAIL wrap_ffc got pc=%h instr=%h exp pc=ffc instr=13ff", out_pc, out_instr);
    end
    tick();
    checks++;
    if (out_pc !== 32'h1000 || out_instr !== 32'h1000) begin
      failures++;
      $display("FAIL wrap_1000 got pc=%h instr=%h exp pc=1000 instr=1000", out_pc, out_instr);
    end
    tick();
    checks++;
    if (out_pc !== 32'h1004 || out_instr !== 32'h1001) begin
      failures++;
      $display("FAIL wrap_1004 got pc=%h instr=%h exp pc=1004 instr=1001", out_pc, out_instr);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0 || rom_addr !== 10'd0) begin
      failures++;
      $display("FAIL async_reset got v=%0b pc=%h instr=%h rom_addr=%h exp all 0",
               out_valid, out_pc, out_instr, rom_addr);
    end
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== 32'h1000) begin
      failures++;
      $display("FAIL after_reset got v=%0b pc=%h instr=%h exp v=1 pc=0 instr=1000",
               out_valid, out_pc, out_instr);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
